// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the multi-cycle instruction sequencer: state encodings,
// ALU control width, captured control bundle and the default MEM timeout.
package cpu_sequencer_pkg;

  localparam int ALU_CTRL_W          = 4;
  localparam int MEM_TIMEOUT_DEFAULT = 15;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4
  } seqState_e;

  typedef struct packed {
    logic                  regdst;
    logic                  regwrite;
    logic                  alusrc;
    logic                  memread;
    logic                  memwrite;
    logic                  memtoreg;
    logic [ALU_CTRL_W-1:0] aluctrl;
  } ctrl_t;

endpackage

// File: rtl/cpu_sequencer_timeout_ctr.sv
// Counts MEM cycles of the current transfer; expired marks the last cycle
// the sequencer may still wait for mem_ack.
module seq_timeout_ctr #(
  parameter int LIMIT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LimitC = 8'(LIMIT);

  logic [7:0] count_q;

  // load marks the first MEM cycle, so the count equals MEM cycles elapsed
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= 8'd1;
    end else if (enable && !expired) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign expired = (count_q == LimitC);

endmodule

// File: rtl/cpu_sequencer.sv
// Five-state IDLE/ID/EX/MEM/WB sequencer that latches an instruction, holds its
// decoded datapath configuration and issues one-cycle memory/writeback strobes.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [31:0]           instrword,
  output logic [31:0]           instr_q,
  input  logic                  c_regdst,
  input  logic                  c_regwrite,
  input  logic                  c_alusrc,
  input  logic                  c_memread,
  input  logic                  c_memwrite,
  input  logic                  c_memtoreg,
  input  logic [ALU_CTRL_W-1:0] c_aluctrl,
  input  logic                  mem_ack,
  output logic                  d_regdst,
  output logic                  d_alusrc,
  output logic                  d_memtoreg,
  output logic [ALU_CTRL_W-1:0] d_aluctrl,
  output logic                  d_memread,
  output logic                  d_memwrite,
  output logic                  d_regwrite,
  output logic                  instr_done,
  output logic                  mem_err,
  output logic [2:0]            state_o,
  output logic [31:0]           retired_cnt
);

  seqState_e   state_q;
  ctrl_t       ctrl_q;
  logic [31:0] instrWord_q;
  logic [31:0] retiredCnt_q;
  logic        memRead_q;
  logic        memWrite_q;
  logic        regWrite_q;
  logic        done_q;
  logic        memErr_q;
  logic        memOp;
  logic        holdActive;
  logic        ctrExpired;

  assign memOp      = ctrl_q.memread | ctrl_q.memwrite;
  assign holdActive = (state_q == ST_EX) || (state_q == ST_MEM) || (state_q == ST_WB);

  seq_timeout_ctr #(
    .LIMIT (MEM_TIMEOUT)
  ) uTimeout (
    .clock   (clock),
    .reset   (reset),
    .load    (state_q == ST_EX),
    .enable  (state_q == ST_MEM),
    .expired (ctrExpired)
  );

  // Strobes default low every cycle and are raised only on the edge entering
  // their state, which keeps each exactly one clock wide.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      ctrl_q       <= '0;
      instrWord_q  <= '0;
      retiredCnt_q <= '0;
      memRead_q    <= 1'b0;
      memWrite_q   <= 1'b0;
      regWrite_q   <= 1'b0;
      done_q       <= 1'b0;
      memErr_q     <= 1'b0;
    end else begin
      memRead_q  <= 1'b0;
      memWrite_q <= 1'b0;
      regWrite_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (instr_valid) begin
            instrWord_q <= instrword;
            state_q     <= ST_ID;
          end
        end
        ST_ID: begin
          ctrl_q.regdst   <= c_regdst;
          ctrl_q.regwrite <= c_regwrite;
          ctrl_q.alusrc   <= c_alusrc;
          ctrl_q.memread  <= c_memread;
          ctrl_q.memwrite <= c_memwrite;
          ctrl_q.memtoreg <= c_memtoreg;
          ctrl_q.aluctrl  <= c_aluctrl;
          state_q         <= ST_EX;
        end
        ST_EX: begin
          // A read wins when both memory controls are set
          memRead_q  <= ctrl_q.memread;
          memWrite_q <= ctrl_q.memwrite & ~ctrl_q.memread;
          state_q    <= ST_MEM;
        end
        ST_MEM: begin
          if (!memOp || mem_ack) begin
            regWrite_q   <= ctrl_q.regwrite;
            done_q       <= 1'b1;
            retiredCnt_q <= retiredCnt_q + 32'd1;
            state_q      <= ST_WB;
          end else if (ctrExpired) begin
            memErr_q <= 1'b1;
            state_q  <= ST_IDLE;
          end
        end
        ST_WB: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign instr_q     = instrWord_q;
  assign state_o     = state_q;
  assign retired_cnt = retiredCnt_q;
  assign mem_err     = memErr_q;
  assign d_memread   = memRead_q;
  assign d_memwrite  = memWrite_q;
  assign d_regwrite  = regWrite_q;
  assign instr_done  = done_q;
  assign d_regdst    = holdActive & ctrl_q.regdst;
  assign d_alusrc    = holdActive & ctrl_q.alusrc;
  assign d_memtoreg  = holdActive & ctrl_q.memtoreg;
  assign d_aluctrl   = holdActive ? ctrl_q.aluctrl : '0;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized bench for cpu_sequencer: the bench decodes instr_q itself and
// predicts each cycle from the instruction class and the chosen ack delay.
module tb_cpu_sequencer;

  localparam int TIMEOUT = 15;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instrword = '0;
  logic [31:0] instr_q;
  logic        c_regdst, c_regwrite, c_alusrc, c_memread, c_memwrite, c_memtoreg;
  logic [3:0]  c_aluctrl;
  logic        mem_ack = 1'b0;
  logic        d_regdst, d_alusrc, d_memtoreg;
  logic [3:0]  d_aluctrl;
  logic        d_memread, d_memwrite, d_regwrite;
  logic        instr_done, mem_err;
  logic [2:0]  state_o;
  logic [31:0] retired_cnt;

  int          testsRun = 0;
  int          testsFailed = 0;
  logic [31:0] modelCnt = '0;
  bit          modelErr = 1'b0;

  cpu_sequencer #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instrword(instrword), .instr_q(instr_q),
    .c_regdst(c_regdst), .c_regwrite(c_regwrite), .c_alusrc(c_alusrc),
    .c_memread(c_memread), .c_memwrite(c_memwrite), .c_memtoreg(c_memtoreg),
    .c_aluctrl(c_aluctrl), .mem_ack(mem_ack),
    .d_regdst(d_regdst), .d_alusrc(d_alusrc), .d_memtoreg(d_memtoreg), .d_aluctrl(d_aluctrl),
    .d_memread(d_memread), .d_memwrite(d_memwrite), .d_regwrite(d_regwrite),
    .instr_done(instr_done), .mem_err(mem_err), .state_o(state_o), .retired_cnt(retired_cnt)
  );

  always #5 clock = ~clock;

  // Instruction word layout used by this bench's decoder
  assign c_aluctrl  = instr_q[3:0];
  assign c_regdst   = instr_q[4];
  assign c_regwrite = instr_q[5];
  assign c_alusrc   = instr_q[6];
  assign c_memread  = instr_q[7];
  assign c_memwrite = instr_q[8];
  assign c_memtoreg = instr_q[9];

  function automatic logic [31:0] mkWord(input logic [3:0] alu, input bit regdst, regwrite,
                                         alusrc, memread, memwrite, memtoreg);
    logic [21:0] upper;
    upper = 22'($urandom);
    return {upper, memtoreg, memwrite, memread, alusrc, regwrite, regdst, alu};
  endfunction

  function automatic logic [31:0] obsVec();
    return {16'd0, state_o, instr_ready, d_memread, d_memwrite, d_regwrite, instr_done,
            d_regdst, d_alusrc, d_memtoreg, d_aluctrl, mem_err};
  endfunction

  function automatic logic [31:0] expVec(input logic [2:0] st, input bit rd, wr, rw, done,
                                         held, input logic [31:0] word, input bit err);
    logic [6:0] hold;
    hold = held ? {word[4], word[6], word[9], word[3:0]} : 7'd0;
    return {16'd0, st, (st == 3'd0), rd, wr, rw, done, hold, err};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "/idle"}, obsVec(), expVec(3'd0, 0, 0, 0, 0, 0, '0, modelErr));
    checkOutput({tag, "/cnt"}, retired_cnt, modelCnt);
  endtask

  // Offer one instruction from IDLE and check every cycle until IDLE returns
  task automatic applyStimulus(input string tag, input logic [31:0] word, input int ackDelay,
                               input bit holdValid);
    bit         rd, wr, retire, held;
    int         m, total, j;
    logic [2:0] st;
    rd = word[7];
    wr = word[8];
    if (!(rd || wr))          begin m = 1;            retire = 1; end
    else if (ackDelay < TIMEOUT) begin m = ackDelay + 1; retire = 1; end
    else                      begin m = TIMEOUT;      retire = 0; end
    total = 2 + m + (retire ? 1 : 0);
    checkIdle(tag);
    instr_valid = 1'b1;
    instrword   = word;
    mem_ack     = 1'($urandom);
    for (int k = 0; k < total; k++) begin
      @(negedge clock);
      j = k - 2;
      if (k == 0)          st = 3'd1;
      else if (k == 1)     st = 3'd2;
      else if (k < 2 + m)  st = 3'd3;
      else                 st = 3'd4;
      held = (k >= 1);
      checkOutput($sformatf("%s/k%0d", tag, k), obsVec(),
                  expVec(st, (st == 3'd3) && (j == 0) && rd,
                         (st == 3'd3) && (j == 0) && wr && !rd,
                         (st == 3'd4) && word[5], (st == 3'd4), held, word, modelErr));
      if (k == 0) checkOutput({tag, "/instr_q"}, instr_q, word);
      instr_valid = holdValid ? 1'b1 : 1'($urandom);
      instrword   = $urandom;
      if (st == 3'd3 && (rd || wr)) mem_ack = (j == ackDelay);
      else                          mem_ack = 1'($urandom);
    end
    @(negedge clock);
    if (retire) modelCnt = modelCnt + 32'd1;
    else        modelErr = 1'b1;
    instr_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] word;
    int          ackDelay;
    #12;
    checkOutput("reset/vec", obsVec(), expVec(3'd0, 0, 0, 0, 0, 0, '0, 1'b0));
    checkOutput("reset/instr_q", instr_q, 32'd0);
    checkOutput("reset/cnt", retired_cnt, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    applyStimulus("add", mkWord(4'b0010, 1, 1, 0, 0, 0, 0), 0, 0);
    applyStimulus("lw", mkWord(4'b0010, 0, 1, 1, 1, 0, 1), 2, 0);
    applyStimulus("sw_timeout", mkWord(4'b0010, 0, 0, 1, 0, 1, 0), 1000, 0);
    applyStimulus("rdwr", mkWord(4'b0110, 0, 1, 1, 1, 1, 1), 0, 0);
    applyStimulus("sw_zero", mkWord(4'b0010, 0, 0, 1, 0, 1, 0), 0, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus($sformatf("b2b%0d", i), mkWord(4'($urandom), 1, 1, 0, 0, 0, 0), 0, 1);

    for (int i = 0; i < 40; i++) begin
      word = $urandom;
      ackDelay = ($urandom_range(0, 7) == 0) ? TIMEOUT + 3 : $urandom_range(0, 4);
      applyStimulus($sformatf("rnd%0d", i), word, ackDelay, 1'($urandom));
    end

    // Reset while a load is in its first MEM cycle
    checkIdle("rstmid");
    instr_valid = 1'b1;
    instrword   = mkWord(4'b0010, 0, 1, 1, 1, 0, 1);
    mem_ack     = 1'b0;
    @(negedge clock);
    instr_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checkOutput("rstmid/inMem", {29'd0, state_o}, 32'd3);
    #2 reset = 1'b0;
    #1;
    modelCnt = '0;
    modelErr = 1'b0;
    checkOutput("rstmid/vec", obsVec(), expVec(3'd0, 0, 0, 0, 0, 0, '0, 1'b0));
    checkOutput("rstmid/instr_q", instr_q, 32'd0);
    checkOutput("rstmid/cnt", retired_cnt, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    applyStimulus("afterRst", mkWord(4'b0010, 0, 1, 1, 1, 0, 1), 1, 0);

    // Counter wrap from all-ones
    force dut.retiredCnt_q = 32'hFFFF_FFFF;
    #1 release dut.retiredCnt_q;
    modelCnt = 32'hFFFF_FFFF;
    applyStimulus("wrap", mkWord(4'b0010, 1, 1, 0, 0, 0, 0), 0, 0);
    checkIdle("final");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, max cycles waited in MEM for mem_ack before abort (1..255).
REQ-002 SHALL have ports:
- clock, input, 1: sole clock; all state updates on posedge.
- reset, input, 1: asynchronous, active-low reset.
- instr_valid, input, 1: new instruction offered.
- instr_ready, output, 1: sequencer can accept.
- instrword, input, 32: offered instruction.
- instr_q, output, 32: latched instruction to decoder/datapath.
- c_regdst, c_regwrite, c_alusrc, c_memread, c_memwrite, c_memtoreg, input, 1 each: decoded controls for instr_q.
- c_aluctrl, input, 4: ALU control for instr_q.
- mem_ack, input, 1: memory transfer complete.
- d_regdst, d_alusrc, d_memtoreg, output, 1 each: held datapath configuration.
- d_aluctrl, output, 4: held ALU control.
- d_memread, d_memwrite, d_regwrite, output, 1 each: single-cycle strobes.
- instr_done, output, 1: retire pulse.
- mem_err, output, 1: sticky timeout flag.
- state_o, output, 3: current state encoding.
- retired_cnt, output, 32: retired-instruction counter.

Function
REQ-003 SHALL implement states IDLE=0, ID=1, EX=2, MEM=3, WB=4; other encodings SHALL go to IDLE next cycle.
REQ-004 instr_ready SHALL be 1 only in IDLE; handshake = instr_valid & instr_ready at a posedge.
REQ-005 On handshake, instr_q SHALL load instrword and state SHALL go IDLE->ID; instr_valid outside IDLE SHALL be ignored.
REQ-006 ID SHALL last one cycle; on ID->EX edge c_* SHALL be captured into an internal control register.
REQ-007 d_regdst, d_alusrc, d_memtoreg, d_aluctrl SHALL be driven from the captured register from EX through WB, and SHALL be 0 in IDLE and ID.
REQ-008 EX SHALL last one cycle, then go to MEM.
REQ-009 In MEM with neither captured memread nor memwrite: one cycle, no strobe, then WB.
REQ-010 In MEM with memread (or memwrite): d_memread (or d_memwrite) SHALL be 1 only in the first MEM cycle; wait until mem_ack=1 sampled, then WB next cycle.
REQ-011 mem_ack sampled in the first MEM cycle SHALL be accepted (zero-wait memory).
REQ-012 If captured memread and memwrite are both 1, only d_memread SHALL pulse; memwrite ignored.
REQ-013 MEM wait counter SHALL count MEM cycles; if MEM_TIMEOUT cycles elapse without mem_ack: set mem_err, go to IDLE, no d_regwrite, no instr_done, retired_cnt unchanged.
REQ-014 mem_err SHALL stay 1 until reset.
REQ-015 mem_ack outside MEM SHALL be ignored.
REQ-016 WB SHALL last one cycle: d_regwrite = captured regwrite; instr_done = 1; retired_cnt increments by 1 (wraps 0xFFFFFFFF->0); then IDLE.
REQ-017 Latency: non-memory instruction, handshake at edge N -> WB cycle between edges N+3 and N+4; next handshake possible at edge N+5.
REQ-018 All strobes and instr_done SHALL be exactly one clock wide, never combinationally from inputs.

Reset
REQ-019 While reset=0: state=IDLE, instr_q=0, captured controls=0, all d_* =0, instr_done=0, mem_err=0, retired_cnt=0, wait counter=0, asynchronously.
REQ-020 Reset asserted mid-instruction SHALL abort it with no further strobes; after release, first edge behaves as IDLE.

Structure
REQ-021 Shared package SHALL hold state encodings, the 4-bit ALU control width and the MEM_TIMEOUT default.
REQ-022 Single module; the MEM wait counter SHALL be a sub-module seq_timeout_ctr (load, enable, expired).

Verification
REQ-023 R-type add (c_regwrite=1, aluctrl=0010) offered cycle 0 -> state sequence 1,2,3,4,0; d_regwrite and instr_done 1 in cycle 4 only; retired_cnt=1.
REQ-024 lw with mem_ack after 3 MEM cycles -> d_memread 1 for first MEM cycle only; MEM lasts 3 cycles; d_memtoreg=1 EX..WB; d_regwrite pulses.
REQ-025 sw, mem_ack never asserted, MEM_TIMEOUT=15 -> after 15 MEM cycles state=0, mem_err=1, no instr_done, retired_cnt unchanged.
REQ-026 instr_valid held high continuously with 3 back-to-back R-types -> accepts only in IDLE, 5-cycle spacing, retired_cnt=3.
REQ-027 reset=0 during MEM of lw -> all outputs 0 immediately, state=0; after release next instruction retires normally.
REQ-028 Preload retired_cnt to 0xFFFFFFFF (force), retire one -> retired_cnt=0.
